// File: rtl/enc_menu_pkg.sv
// Shared definitions for the rotary-encoder menu controller: defaults,
// the menu state encoding and the hold-counter width.
package enc_menu_pkg;

    localparam int NPARAM_DEF   = 4;
    localparam int DW_DEF       = 8;
    localparam int LONG_CYC_DEF = 2000;
    localparam int CNT_W        = 12;

    localparam logic [7:0] DEF_VAL = 8'h80;

    typedef enum logic [1:0] {
        ST_BROWSE = 2'd0,
        ST_EDIT   = 2'd1,
        ST_WRITE  = 2'd2,
        ST_HOLD   = 2'd3
    } menu_state_e;

endpackage

// File: rtl/enc_menu_ctrl_pb_press_timer.sv
// Pushbutton press classifier: edge detection on pb (0 = pressed) and a
// saturating hold counter producing short_press / long_press pulses.
module pb_press_timer #(
    parameter int LONG_CYC = enc_menu_pkg::LONG_CYC_DEF,
    parameter int CW       = enc_menu_pkg::CNT_W
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic pb_i,
    output logic short_press_o,
    output logic long_press_o
);

    localparam logic [CW-1:0] LIMIT = CW'(LONG_CYC);

    logic          pb_q;
    logic          armed_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          press_start_s;
    logic          held_s;
    logic          release_s;

    // armed_q stays low until pb has been seen released, so a press held
    // across reset is ignored until it is released and pressed again
    assign press_start_s = armed_q & pb_q & ~pb_i;
    assign held_s        = armed_q & ~pb_i;
    assign release_s     = armed_q & ~pb_q & pb_i;

    // Hold count: the press-start cycle counts as held cycle 1
    always_comb begin
        cnt_d = cnt_q;
        if (press_start_s) begin
            cnt_d = CW'(1);
        end else if (held_s && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign long_press_o  = held_s && (cnt_d == LIMIT) && (press_start_s || (cnt_q != LIMIT));
    assign short_press_o = release_s && (cnt_q < LIMIT);

    // Registered pb, arming flag and hold counter
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pb_q    <= 1'b1;
            armed_q <= 1'b0;
            cnt_q   <= {CW{1'b0}};
        end else begin
            pb_q    <= pb_i;
            armed_q <= armed_q | pb_i;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/enc_menu_ctrl.sv
// Encoder-driven menu: browse registers, edit a value, write it downstream
// through a valid/ready handshake, with long-press abort into HOLD.
module enc_menu_ctrl #(
    parameter int                NPARAM   = enc_menu_pkg::NPARAM_DEF,
    parameter int                DW       = enc_menu_pkg::DW_DEF,
    parameter int                LONG_CYC = enc_menu_pkg::LONG_CYC_DEF,
    parameter logic [DW-1:0]     DEF_VAL  = DW'(enc_menu_pkg::DEF_VAL),
    localparam int               SW       = (NPARAM > 1) ? $clog2(NPARAM) : 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          inc_i,
    input  logic          dec_i,
    input  logic          pb_i,
    input  logic          cfg_ready_i,
    output logic [SW-1:0] sel_o,
    output logic          editing_o,
    output logic [DW-1:0] edit_val_o,
    output logic          cfg_valid_o,
    output logic [SW-1:0] cfg_addr_o,
    output logic [DW-1:0] cfg_data_o,
    output logic          long_press_o
);

    import enc_menu_pkg::*;

    menu_state_e   state_q;
    logic [SW-1:0] sel_q;
    logic [DW-1:0] edit_val_q;
    logic          cfg_valid_q;
    logic [SW-1:0] cfg_addr_q;
    logic [DW-1:0] cfg_data_q;
    logic          long_press_q;
    logic [DW-1:0] shadow_q [NPARAM];

    logic short_s;
    logic long_s;
    logic inc_s;
    logic dec_s;

    pb_press_timer #(
        .LONG_CYC (LONG_CYC),
        .CW       (CNT_W)
    ) u_timer (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .pb_i          (pb_i),
        .short_press_o (short_s),
        .long_press_o  (long_s)
    );

    // Simultaneous inc and dec cancel out
    assign inc_s = inc_i & ~dec_i;
    assign dec_s = dec_i & ~inc_i;

    // Menu FSM with all outputs and the shadow copies held in registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_BROWSE;
            sel_q        <= {SW{1'b0}};
            edit_val_q   <= {DW{1'b0}};
            cfg_valid_q  <= 1'b0;
            cfg_addr_q   <= {SW{1'b0}};
            cfg_data_q   <= {DW{1'b0}};
            long_press_q <= 1'b0;
            for (int i = 0; i < NPARAM; i++) begin
                shadow_q[i] <= DEF_VAL;
            end
        end else begin
            long_press_q <= long_s;
            case (state_q)
                ST_BROWSE: begin
                    if (long_s) begin
                        state_q <= ST_HOLD;
                    end else if (short_s) begin
                        edit_val_q <= shadow_q[sel_q];
                        state_q    <= ST_EDIT;
                    end else if (inc_s) begin
                        sel_q <= (sel_q == SW'(NPARAM - 1)) ? {SW{1'b0}} : sel_q + 1'b1;
                    end else if (dec_s) begin
                        sel_q <= (sel_q == {SW{1'b0}}) ? SW'(NPARAM - 1) : sel_q - 1'b1;
                    end
                end
                ST_EDIT: begin
                    if (long_s) begin
                        state_q <= ST_HOLD;
                    end else if (short_s) begin
                        cfg_valid_q <= 1'b1;
                        cfg_addr_q  <= sel_q;
                        cfg_data_q  <= edit_val_q;
                        state_q     <= ST_WRITE;
                    end else if (inc_s && (edit_val_q != {DW{1'b1}})) begin
                        edit_val_q <= edit_val_q + 1'b1;
                    end else if (dec_s && (edit_val_q != {DW{1'b0}})) begin
                        edit_val_q <= edit_val_q - 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (cfg_ready_i) begin
                        shadow_q[sel_q] <= cfg_data_q;
                        cfg_valid_q     <= 1'b0;
                        state_q         <= ST_BROWSE;
                    end
                end
                ST_HOLD: begin
                    if (pb_i) begin
                        state_q <= ST_BROWSE;
                    end
                end
                default: begin
                    cfg_valid_q <= 1'b0;
                    state_q     <= ST_BROWSE;
                end
            endcase
        end
    end

    assign sel_o        = sel_q;
    assign editing_o    = (state_q == ST_EDIT);
    assign edit_val_o   = edit_val_q;
    assign cfg_valid_o  = cfg_valid_q;
    assign cfg_addr_o   = cfg_addr_q;
    assign cfg_data_o   = cfg_data_q;
    assign long_press_o = long_press_q;

endmodule

// File: tb/tb_enc_menu_ctrl.sv
// Directed bench for enc_menu_ctrl: writes are scoreboarded through a
// queue of expected {addr,data}; everything else is checked inline.
module tb_enc_menu_ctrl;

    localparam logic [7:0] DEF = 8'h80;

    logic       clk = 1'b0;
    logic       reset;
    logic       inc;
    logic       dec;
    logic       pb;
    logic       cfg_ready;
    logic [1:0] sel;
    logic       editing;
    logic [7:0] edit_val;
    logic       cfg_valid;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       long_press;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [9:0] exp_q [$];
    logic [7:0] shadow_m [4];
    logic [7:0] ev_m;

    always #5 clk = ~clk;

    enc_menu_ctrl dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .inc_i        (inc),
        .dec_i        (dec),
        .pb_i         (pb),
        .cfg_ready_i  (cfg_ready),
        .sel_o        (sel),
        .editing_o    (editing),
        .edit_val_o   (edit_val),
        .cfg_valid_o  (cfg_valid),
        .cfg_addr_o   (cfg_addr),
        .cfg_data_o   (cfg_data),
        .long_press_o (long_press)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic i, input logic d);
        inc = i;
        dec = d;
        tick();
        inc = 1'b0;
        dec = 1'b0;
    endtask

    task automatic short_press();
        pb = 1'b0;
        tick();
        pb = 1'b1;
        tick();
    endtask

    // Wait (bounded) for valid&ready, then compare against the scoreboard
    task automatic handshake();
        logic [9:0] e;
        bit         done;
        done = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            if (cfg_valid && cfg_ready) begin
                done = 1'b1;
                check("sb_nonempty", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("cfg_addr", cfg_addr, e[9:8]);
                    check("cfg_data", cfg_data, e[7:0]);
                    shadow_m[e[9:8]] = e[7:0];
                end
            end
            tick();
        end
        check("hs_seen", done, 1);
        check("valid_drop", cfg_valid, 0);
    endtask

    initial begin
        int pulses;
        int at;
        reset = 1'b1; inc = 1'b0; dec = 1'b0; pb = 1'b1; cfg_ready = 1'b0;
        for (int i = 0; i < 4; i++) shadow_m[i] = DEF;
        tick(); tick();
        check("rst_sel", sel, 0);
        check("rst_editing", editing, 0);
        check("rst_edit_val", edit_val, 0);
        check("rst_valid", cfg_valid, 0);
        check("rst_addr", cfg_addr, 0);
        check("rst_data", cfg_data, 0);
        check("rst_long", long_press, 0);
        reset = 1'b0;
        tick();

        // dec wraps 0 -> 3 and walks down
        pulse(0, 1); check("dec1_sel", sel, 3); check("dec1_valid", cfg_valid, 0);
        pulse(0, 1); check("dec2_sel", sel, 2); check("dec2_valid", cfg_valid, 0);
        pulse(0, 1); check("dec3_sel", sel, 1); check("dec3_valid", cfg_valid, 0);
        pulse(1, 0); check("inc_sel", sel, 2);

        // edit sel 2 up to 0x85 and write with a stalled ready
        short_press();
        check("edit_enter", editing, 1);
        check("edit_load", edit_val, shadow_m[2]);
        for (int i = 0; i < 5; i++) pulse(1, 0);
        check("edit_85", edit_val, 8'h85);
        exp_q.push_back({2'd2, 8'h85});
        short_press();
        check("write_valid", cfg_valid, 1);
        check("write_editing", editing, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", cfg_valid, 1);
            check("stall_addr", cfg_addr, 2);
            check("stall_data", cfg_data, 8'h85);
        end
        cfg_ready = 1'b1;
        handshake();
        cfg_ready = 1'b0;
        check("post_write_sel", sel, 2);

        // shadow[2] now reads back 0x85; inc+dec together is a no-op
        short_press();
        check("shadow2", edit_val, 8'h85);
        pulse(1, 1);
        check("both_edit", edit_val, 8'h85);
        cfg_ready = 1'b1;
        exp_q.push_back({2'd2, 8'h85});
        short_press();
        handshake();
        cfg_ready = 1'b0;
        pulse(1, 1);
        check("both_browse", sel, 2);

        // saturation at both ends on sel 3
        pulse(1, 0);
        check("sel3", sel, 3);
        short_press();
        ev_m = shadow_m[3];
        for (int i = 0; i < 126; i++) begin
            pulse(1, 0);
            ev_m = ev_m + 8'd1;
        end
        check("edit_fe", edit_val, 8'hFE);
        for (int i = 0; i < 3; i++) begin
            pulse(1, 0);
            ev_m = (ev_m == 8'hFF) ? 8'hFF : ev_m + 8'd1;
            check("sat_hi", edit_val, ev_m);
        end
        check("sat_ff", edit_val, 8'hFF);
        for (int i = 0; i < 254; i++) pulse(0, 1);
        check("edit_01", edit_val, 8'h01);
        ev_m = 8'h01;
        for (int i = 0; i < 3; i++) begin
            pulse(0, 1);
            ev_m = (ev_m == 8'h00) ? 8'h00 : ev_m - 8'd1;
            check("sat_lo", edit_val, ev_m);
        end
        cfg_ready = 1'b1;
        exp_q.push_back({2'd3, 8'h00});
        short_press();
        handshake();
        cfg_ready = 1'b0;

        // long press in EDIT on sel 0 discards the edit
        pulse(1, 0);
        check("wrap_sel0", sel, 0);
        short_press();
        check("edit0_load", edit_val, shadow_m[0]);
        pulse(1, 0); pulse(1, 0);
        check("edit0_82", edit_val, 8'h82);
        pb = 1'b0;
        pulses = 0;
        at = -1;
        for (int k = 1; k <= 2005; k++) begin
            tick();
            if (long_press) begin
                pulses++;
                if (at < 0) at = k;
            end
        end
        check("long_count", pulses, 1);
        check("long_cycle", at, 2000);
        check("hold_editing", editing, 0);
        pulse(1, 0);
        check("hold_sel", sel, 0);
        pb = 1'b1;
        tick();
        check("release_editing", editing, 0);
        pulse(1, 0);
        check("browse_again", sel, 1);
        pulse(0, 1);
        short_press();
        check("discarded", edit_val, 8'h80);

        // reset while WRITE is stalled
        pulse(1, 0);
        short_press();
        check("w2_valid", cfg_valid, 1);
        #2 reset = 1'b1;
        #1 check("async_drop", cfg_valid, 0);
        for (int i = 0; i < 4; i++) shadow_m[i] = DEF;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst2_sel", sel, 0);
        check("rst2_edit_val", edit_val, 0);
        for (int s = 0; s < 4; s++) begin
            short_press();
            check("rst_shadow", edit_val, shadow_m[s]);
            check("rst_shadow_def", edit_val, 8'h80);
            cfg_ready = 1'b1;
            exp_q.push_back({s[1:0], 8'h80});
            short_press();
            handshake();
            cfg_ready = 1'b0;
            pulse(1, 0);
            check("walk_sel", sel, (s + 1) % 4);
        end

        // a press held across reset release is not a press
        pb = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        pb = 1'b1;
        tick();
        check("held_across_rst", editing, 0);
        short_press();
        check("fresh_press", editing, 1);
        check("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
